// File: rtl/blaster_pkg.sv
// blaster_pkg: shared state encoding and command-byte field positions for the USB-Blaster decoder.
package blaster_pkg;
   typedef enum logic [2:0] {IDLE, BB_RSP, SH_WAIT, SH_LOW, SH_HIGH, SH_RSP} state_t;
   localparam int BB_TCK    = 0;
   localparam int BB_TMS    = 1;
   localparam int BB_NCE    = 2;
   localparam int BB_NCS    = 3;
   localparam int BB_TDI    = 4;
   localparam int BB_LED    = 5;
   localparam int BB_READ   = 6;
   localparam int HDR_SHIFT = 7;
   localparam int HDR_READ  = 6;
   localparam int CNT_W     = 6;
endpackage

// File: rtl/blaster_tck_phase.sv
// blaster_tck_phase: TCK half-period timer; start reloads it, done is high on the last cycle of the phase.
module blaster_tck_phase #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic done
);
   localparam int W = $clog2(CLK_DIV + 1);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (start) cnt <= W'(CLK_DIV - 1);
      else if (cnt != '0) cnt <= cnt - 1'b1;
   end
   assign done = cnt == '0;
endmodule

// File: rtl/blaster_cmd_decoder.sv
// blaster_cmd_decoder: decodes USB-Blaster bit-bang and byte-shift commands into JTAG/AS pin activity.
module blaster_cmd_decoder
   import blaster_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_cmd_data,
   input  logic       i_cmd_valid,
   output logic       o_cmd_ready,
   output logic [7:0] o_rsp_data,
   output logic       o_rsp_valid,
   input  logic       i_rsp_ready,
   output logic       o_tck,
   output logic       o_tms,
   output logic       o_tdi,
   output logic       o_nce,
   output logic       o_ncs,
   output logic       o_led,
   input  logic       i_tdo,
   input  logic       i_asdo,
   output logic       o_activity
);
   state_t state, state_nx;
   logic [CNT_W-1:0] n;
   logic rd, start, done, accept, last_bit;
   logic [7:0] shreg, cap;
   logic [2:0] idx;

   blaster_tck_phase #(.CLK_DIV(CLK_DIV)) u_phase (
      .clk(i_clk), .rst_n(i_rst_n), .start(start), .done(done)
   );

   // ready is gated by reset so nothing is consumed while held in reset
   assign o_cmd_ready = i_rst_n && (state == IDLE || state == SH_WAIT);
   assign accept = i_cmd_valid && o_cmd_ready;
   assign o_activity = accept;
   assign o_rsp_valid = state == BB_RSP || state == SH_RSP;
   assign last_bit = idx == 3'd7;

   always_comb begin
      state_nx = state;
      start = 1'b0;
      case (state)
         IDLE:    if (accept) state_nx = i_cmd_data[HDR_SHIFT]
                     ? (i_cmd_data[CNT_W-1:0] != '0 ? SH_WAIT : IDLE)
                     : (i_cmd_data[BB_READ] ? BB_RSP : IDLE);
         BB_RSP:  if (i_rsp_ready) state_nx = IDLE;
         SH_WAIT: if (accept) begin
            state_nx = SH_LOW;
            start = 1'b1;
         end
         SH_LOW:  if (done) begin
            state_nx = SH_HIGH;
            start = 1'b1;
         end
         SH_HIGH: if (done) begin
            start = !last_bit;
            state_nx = !last_bit ? SH_LOW : rd ? SH_RSP : n > CNT_W'(1) ? SH_WAIT : IDLE;
         end
         SH_RSP:  if (i_rsp_ready) state_nx = n != '0 ? SH_WAIT : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         o_tck <= 1'b0;
         o_tms <= 1'b0;
         o_tdi <= 1'b0;
         o_led <= 1'b0;
         o_nce <= 1'b1;
         o_ncs <= 1'b1;
         o_rsp_data <= '0;
         n <= '0;
         rd <= 1'b0;
         shreg <= '0;
         cap <= '0;
         idx <= '0;
      end else begin
         state <= state_nx;
         if (accept && state == IDLE && !i_cmd_data[HDR_SHIFT]) begin
            o_tck <= i_cmd_data[BB_TCK];
            o_tms <= i_cmd_data[BB_TMS];
            o_nce <= i_cmd_data[BB_NCE];
            o_ncs <= i_cmd_data[BB_NCS];
            o_tdi <= i_cmd_data[BB_TDI];
            o_led <= i_cmd_data[BB_LED];
            if (i_cmd_data[BB_READ]) o_rsp_data <= {6'b0, i_asdo, i_tdo};
         end
         if (accept && state == IDLE && i_cmd_data[HDR_SHIFT]) begin
            n <= i_cmd_data[CNT_W-1:0];
            rd <= i_cmd_data[HDR_READ];
         end
         if (accept && state == SH_WAIT) begin
            shreg <= i_cmd_data;
            idx <= '0;
            o_tck <= 1'b0;
            o_tdi <= i_cmd_data[0];
         end
         if (state == SH_LOW && done) begin
            o_tck <= 1'b1;
            cap[idx] <= i_tdo;
         end
         if (state == SH_HIGH && done) begin
            o_tck <= 1'b0;
            if (last_bit) begin
               n <= n - 1'b1;
               if (rd) o_rsp_data <= cap;
            end else begin
               idx <= idx + 3'd1;
               o_tdi <= shreg[idx + 3'd1];
            end
         end
      end
   end
endmodule

// File: tb/tb_blaster_cmd_decoder.sv
// tb_blaster_cmd_decoder: scenario tasks with a response scoreboard and a pin-activity monitor.
module tb_blaster_cmd_decoder;
   localparam int CLK_DIV = 2;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [7:0] cmd_data = '0, rsp_data;
   logic cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0;
   logic tck, tms, tdi, nce, ncs, led, tdo, activity;
   logic asdo = 1'b0, loopback = 1'b0, tdo_drv = 1'b0;
   int checks = 0, errors = 0;
   int cyc = 0, act_cnt = 0, valid_cyc = 0, rises = 0, hi_len = 0, hi_bad = 0, rdy_viol = 0;
   int acc_last = 0, acc_prev = 0;
   logic [7:0] tdi_sr = '0;
   logic tck_q = 1'b0;
   logic [7:0] exp_q[$];

   assign tdo = loopback ? tdi : tdo_drv;
   always #5 clk = ~clk;

   blaster_cmd_decoder #(.CLK_DIV(CLK_DIV)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cmd_data(cmd_data), .i_cmd_valid(cmd_valid),
      .o_cmd_ready(cmd_ready), .o_rsp_data(rsp_data), .o_rsp_valid(rsp_valid),
      .i_rsp_ready(rsp_ready), .o_tck(tck), .o_tms(tms), .o_tdi(tdi), .o_nce(nce),
      .o_ncs(ncs), .o_led(led), .i_tdo(tdo), .i_asdo(asdo), .o_activity(activity)
   );

   // pin monitor sampled mid-cycle: TCK pulses, high widths, TDI bits seen at each rise
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (activity) begin
         act_cnt <= act_cnt + 1;
         acc_prev <= acc_last;
         acc_last <= cyc;
      end
      if (rsp_valid) valid_cyc <= valid_cyc + 1;
      if (tck && !tck_q) begin
         rises <= rises + 1;
         tdi_sr <= {tdi, tdi_sr[7:1]};
      end
      if (tck) hi_len <= hi_len + 1;
      else if (tck_q) begin
         if (hi_len != CLK_DIV) hi_bad <= hi_bad + 1;
         hi_len <= 0;
      end
      if (tck && cmd_ready) rdy_viol <= rdy_viol + 1;
      tck_q <= tck;
   end

   task automatic send(input logic [7:0] b);
      int t;
      t = 0;
      cmd_data = b;
      cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready) begin
         t++;
         if (t > 300) begin
            $display("FAIL send_%h: o_cmd_ready stayed 0 for %0d cycles, required 1", b, t);
            $fatal(1, "stalled");
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic [7:0] d);
      int t;
      t = 0;
      @(negedge clk);
      while (!rsp_valid) begin
         t++;
         if (t > 300) begin
            $display("FAIL rsp_wait: o_rsp_valid stayed 0 for %0d cycles, required 1", t);
            $fatal(1, "stalled");
         end
         @(negedge clk);
      end
      d = rsp_data;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      cmd_data = 8'h5F;
      cmd_valid = 1'b1;
      #12;
      checks++;
      if ({tck, tms, tdi, led, nce, ncs, rsp_valid, cmd_ready, activity} !== 9'b0000_1100_0) begin
         errors++;
         $display("FAIL rst_pins: got %b required %b",
            {tck, tms, tdi, led, nce, ncs, rsp_valid, cmd_ready, activity}, 9'b0000_1100_0);
      end
      checks++;
      if (rsp_data !== 8'h00) begin
         errors++;
         $display("FAIL rst_rsp_data: got %h required 00", rsp_data);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({cmd_ready, rsp_valid, act_cnt} !== {1'b1, 1'b0, 32'd0}) begin
         errors++;
         $display("FAIL rst_release: ready/valid/act got %b/%b/%0d required 1/0/0",
            cmd_ready, rsp_valid, act_cnt);
      end
   endtask

   task automatic test_bitbang_read;
      int a0;
      logic [7:0] d, e;
      a0 = act_cnt;
      tdo_drv = 1'b1;
      asdo = 1'b0;
      exp_q.push_back(8'h01);
      send(8'h5F);
      checks++;
      if ({tck, tms, nce, ncs, tdi, led} !== 6'b111110) begin
         errors++;
         $display("FAIL bb_read_pins: got %b required 111110", {tck, tms, nce, ncs, tdi, led});
      end
      checks++;
      if ({rsp_valid, cmd_ready} !== 2'b10) begin
         errors++;
         $display("FAIL bb_rsp_state: valid/ready got %b required 10", {rsp_valid, cmd_ready});
      end
      get_rsp(d);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin
         errors++;
         $display("FAIL bb_rsp_data: got %h required %h", d, e);
      end
      checks++;
      if (act_cnt - a0 !== 1) begin
         errors++;
         $display("FAIL bb_activity: got %0d pulses required 1", act_cnt - a0);
      end
   endtask

   task automatic test_bitbang_noread;
      int v0;
      v0 = valid_cyc;
      send(8'h12);
      checks++;
      if ({tck, tms, nce, ncs, tdi, led} !== 6'b010010) begin
         errors++;
         $display("FAIL bb_noread_pins: got %b required 010010", {tck, tms, nce, ncs, tdi, led});
      end
      repeat (3) @(negedge clk);
      checks++;
      if (valid_cyc != v0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL bb_noread_idle: valid cycles %0d ready %b required 0 and 1", valid_cyc - v0, cmd_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_shift_read;
      int a0, r0, h0, v0;
      logic [7:0] d, e;
      a0 = act_cnt; r0 = rises; h0 = hi_bad; v0 = rdy_viol;
      loopback = 1'b1;
      exp_q.push_back(8'hA5);
      send(8'hC1);
      send(8'hA5);
      get_rsp(d);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin
         errors++;
         $display("FAIL shr_rsp_data: got %h required %h", d, e);
      end
      checks++;
      if (rises - r0 != 8 || hi_bad != h0) begin
         errors++;
         $display("FAIL shr_tck: pulses %0d bad widths %0d required 8 and 0", rises - r0, hi_bad - h0);
      end
      checks++;
      if (act_cnt - a0 != 2 || rdy_viol != v0) begin
         errors++;
         $display("FAIL shr_act_ready: pulses %0d ready-high %0d required 2 and 0", act_cnt - a0, rdy_viol - v0);
      end
      checks++;
      if ({cmd_ready, rsp_valid, tms, nce, ncs, led} !== 6'b101000) begin
         errors++;
         $display("FAIL shr_end: got %b required 101000", {cmd_ready, rsp_valid, tms, nce, ncs, led});
      end
      loopback = 1'b0;
   endtask

   task automatic test_shift_noread;
      int r0, h0, v0, w0, t;
      r0 = rises; h0 = hi_bad; v0 = rdy_viol; w0 = valid_cyc;
      send(8'h83);
      send(8'h11);
      checks++;
      if (acc_last - acc_prev != 1) begin
         errors++;
         $display("FAIL shn_hdr_gap: got %0d cycles required 1", acc_last - acc_prev);
      end
      for (int i = 0; i < 2; i++) begin
         send(i == 0 ? 8'h22 : 8'h33);
         checks++;
         if (acc_last - acc_prev != 1 + 16 * CLK_DIV) begin
            errors++;
            $display("FAIL shn_byte_gap%0d: got %0d cycles required %0d", i, acc_last - acc_prev, 1 + 16 * CLK_DIV);
         end
      end
      t = 0;
      while (!cmd_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      checks++;
      if (rises - r0 != 24 || hi_bad != h0) begin
         errors++;
         $display("FAIL shn_tck: pulses %0d bad widths %0d required 24 and 0", rises - r0, hi_bad - h0);
      end
      checks++;
      if (tdi_sr !== 8'h33) begin
         errors++;
         $display("FAIL shn_tdi: last byte on TDI got %h required 33", tdi_sr);
      end
      checks++;
      if (valid_cyc != w0 || rdy_viol != v0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL shn_status: valid cycles %0d ready-high %0d ready %b required 0 0 1",
            valid_cyc - w0, rdy_viol - v0, cmd_ready);
      end
   endtask

   task automatic test_zero_header;
      send(8'h80);
      send(8'h25);
      checks++;
      if ({tck, tms, nce, ncs, tdi, led, cmd_ready} !== 7'b1010011) begin
         errors++;
         $display("FAIL zero_hdr: got %b required 1010011", {tck, tms, nce, ncs, tdi, led, cmd_ready});
      end
   endtask

   task automatic test_backpressure;
      int a0, t;
      logic [7:0] d, e;
      loopback = 1'b1;
      exp_q.push_back(8'h3C);
      send(8'hC1);
      send(8'h3C);
      t = 0;
      @(negedge clk);
      while (!rsp_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      e = exp_q.pop_front();
      checks++;
      if (rsp_data !== e) begin
         errors++;
         $display("FAIL bp_rsp_data: got %h required %h", rsp_data, e);
      end
      loopback = 1'b0;
      tdo_drv = 1'b0;
      asdo = 1'b1;
      cmd_data = 8'h40;
      cmd_valid = 1'b1;
      a0 = act_cnt;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({rsp_valid, cmd_ready, rsp_data} !== {2'b10, e}) begin
            errors++;
            $display("FAIL bp_hold%0d: valid/ready/data got %b/%b/%h required 1/0/%h", i, rsp_valid, cmd_ready, rsp_data, e);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      checks++;
      if (act_cnt != a0) begin
         errors++;
         $display("FAIL bp_consumed: %0d bytes taken during backpressure required 0", act_cnt - a0);
      end
      exp_q.push_back(8'h02);
      @(negedge clk);
      checks++;
      if ({cmd_ready, activity} !== 2'b11) begin
         errors++;
         $display("FAIL bp_resume: ready/activity got %b required 11", {cmd_ready, activity});
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      get_rsp(d);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin
         errors++;
         $display("FAIL bp_next_rsp: got %h required %h", d, e);
      end
      asdo = 1'b0;
   endtask

   task automatic test_reset_mid_shift;
      int r0, t, w0;
      send(8'h81);
      send(8'hFF);
      r0 = rises;
      t = 0;
      while (rises != r0 + 4 && t < 300) begin
         @(negedge clk);
         #1;
         t++;
      end
      checks++;
      if (tck !== 1'b1) begin
         errors++;
         $display("FAIL mid_bit3: tck got %b required 1 before reset", tck);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({tck, tms, tdi, led, nce, ncs, rsp_valid, cmd_ready, activity} !== 9'b0000_1100_0) begin
         errors++;
         $display("FAIL mid_rst_pins: got %b required %b",
            {tck, tms, tdi, led, nce, ncs, rsp_valid, cmd_ready, activity}, 9'b0000_1100_0);
      end
      checks++;
      if (rsp_data !== 8'h00) begin
         errors++;
         $display("FAIL mid_rst_data: got %h required 00", rsp_data);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      w0 = valid_cyc;
      send(8'h00);
      repeat (3) @(negedge clk);
      checks++;
      if ({tck, tms, nce, ncs, tdi, led, cmd_ready} !== 7'b0000001 || valid_cyc != w0) begin
         errors++;
         $display("FAIL post_rst_bb: pins/ready got %b valid cycles %0d required 0000001 and 0",
            {tck, tms, nce, ncs, tdi, led, cmd_ready}, valid_cyc - w0);
      end
   endtask

   initial begin
      test_reset();
      test_bitbang_read();
      test_bitbang_noread();
      test_shift_read();
      test_shift_noread();
      test_zero_header();
      test_backpressure();
      test_reset_mid_shift();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
